// File: rtl/clk_div_multi.sv
// clk_div_multi: bank of independent programmable clock dividers.
//
// Each channel divides clk_in by a runtime divisor N with a programmable
// high time H. Writes go to a per-channel shadow pair that is promoted to
// the active pair at the channel's next period boundary, so a running
// output never sees a half-old, half-new period.
//
// Ports:
//   clk_in      - sole clock, everything is on its rising edge
//   reset       - asynchronous, active-high, clears all state
//   en          - per-channel run enable
//   sync        - one-cycle pulse, restarts every channel in phase
//   cfg_wr      - one-cycle configuration write strobe
//   cfg_ch      - target channel of the write
//   cfg_div     - new divisor N (period in clk_in cycles)
//   cfg_high    - new high time H (clk_in cycles)
//   clk_out     - registered divided clocks
//   tick        - one-cycle pulse on each rising edge of clk_out
//   cfg_pending - shadow pair waiting for the channel's period boundary
//   cfg_err     - one-cycle pulse flagging a rejected write
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 100000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic              cfg_err
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);
    localparam logic [31:0]      NUM_CH_U = 32'(NUM_CH);

    logic [CNT_W-1:0]  act_div_q  [NUM_CH];
    logic [CNT_W-1:0]  act_div_d  [NUM_CH];
    logic [CNT_W-1:0]  act_high_q [NUM_CH];
    logic [CNT_W-1:0]  act_high_d [NUM_CH];
    logic [CNT_W-1:0]  sh_div_q   [NUM_CH];
    logic [CNT_W-1:0]  sh_div_d   [NUM_CH];
    logic [CNT_W-1:0]  sh_high_q  [NUM_CH];
    logic [CNT_W-1:0]  sh_high_d  [NUM_CH];
    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic              wr_bad;
    logic              wr_ok;
    logic [CNT_W-1:0]  wr_high;
    logic [NUM_CH-1:0] apply;

    // Next-state logic for every channel. The shadow is promoted whenever a
    // new period starts (wrap, sync, or while disabled); a write on the same
    // edge lands in the shadow afterwards, so the old pending pair is the one
    // applied and the new one stays pending.
    always_comb begin
        wr_bad    = cfg_wr && ((cfg_div < CNT_W'(2)) ||
                               ({{(32-CH_W){1'b0}}, cfg_ch} >= NUM_CH_U));
        wr_ok     = cfg_wr && !wr_bad;
        // Out-of-range high times fall back to a 50% duty cycle.
        wr_high   = ((cfg_high == '0) || (cfg_high >= cfg_div)) ? (cfg_div >> 1) : cfg_high;
        cfg_err_d = wr_bad;

        act_div_d  = act_div_q;
        act_high_d = act_high_q;
        sh_div_d   = sh_div_q;
        sh_high_d  = sh_high_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        clk_out_d  = clk_out_q;
        tick_d     = '0;
        apply      = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (sync || !en[c]) begin
                cnt_d[c]     = '0;
                clk_out_d[c] = 1'b0;
                apply[c]     = pending_q[c];
            end else if (cnt_q[c] == act_div_q[c] - CNT_W'(1)) begin
                cnt_d[c]     = '0;
                clk_out_d[c] = 1'b1;
                tick_d[c]    = 1'b1;
                apply[c]     = pending_q[c];
            end else begin
                if (cnt_q[c] == act_high_q[c] - CNT_W'(1)) begin
                    clk_out_d[c] = 1'b0;
                end
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            if (apply[c]) begin
                act_div_d[c]  = sh_div_q[c];
                act_high_d[c] = sh_high_q[c];
                pending_d[c]  = 1'b0;
            end

            if (wr_ok && (cfg_ch == CH_W'(c))) begin
                sh_div_d[c]  = cfg_div;
                sh_high_d[c] = wr_high;
                pending_d[c] = 1'b1;
            end
        end
    end

    // State registers; reset restores the default divisor on both pairs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                act_div_q[c]  <= RST_DIV;
                act_high_q[c] <= RST_HIGH;
                sh_div_q[c]   <= RST_DIV;
                sh_high_q[c]  <= RST_HIGH;
                cnt_q[c]      <= '0;
            end
            pending_q <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            act_div_q  <= act_div_d;
            act_high_q <= act_high_d;
            sh_div_q   <= sh_div_d;
            sh_high_q  <= sh_high_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: self-checking bench for clk_div_multi.
//
// Three channels are instantiated so that channel index 3 is representable
// on the 2-bit cfg_ch port and exercises the out-of-range rejection. Edge k
// below means the k-th rising clk_in edge after reset release.
module tb_clk_div_multi;

    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 10;
    localparam int CH_W        = 2;

    logic              clk_in = 1'b0;
    logic              reset  = 1'b0;
    logic [NUM_CH-1:0] en     = '0;
    logic              sync   = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div  = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cfg_pending;
    logic              cfg_err;

    typedef struct {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tk;
        logic [NUM_CH-1:0] pend;
        logic              err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .en          (en),
        .sync        (sync),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // High during the first h cycles of each n-cycle period that starts at edge 'start'.
    function automatic logic hi(int k, int start, int n, int h);
        if (k < start) return 1'b0;
        return ((k - start) % n) < h;
    endfunction

    task automatic advance();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        sync   = 1'b0;
        cfg_wr = 1'b0;
    endtask

    task automatic write(int ch, int div, int high);
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(div);
        cfg_high = CNT_W'(high);
    endtask

    task automatic push(logic [NUM_CH-1:0] c, logic [NUM_CH-1:0] t,
                        logic [NUM_CH-1:0] p, logic r);
        exp_t x;
        x.clk  = c;
        x.tk   = t;
        x.pend = p;
        x.err  = r;
        sb.push_back(x);
    endtask

    // Called one time unit after an edge (or at time 0), so release lands mid-cycle.
    task automatic do_reset();
        en = '0;
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = '1;
        write(0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            push('0, '0, '0, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL reset cyc %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
        reset = 1'b0;
    endtask

    task automatic test_default_run();
        do_reset();
        en = 3'b001;
        for (int k = 1; k <= 32; k++) begin
            push({2'b0, hi(k, 10, 10, 5)}, {2'b0, hi(k, 10, 10, 1)}, '0, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL default_run edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
    endtask

    task automatic test_reconfig();
        do_reset();
        en = 3'b001;
        for (int k = 1; k <= 28; k++) begin
            idle();
            if (k == 4) write(0, 4, 1);
            push({2'b0, hi(k, 10, 4, 1)}, {2'b0, hi(k, 10, 4, 1)},
                 {2'b0, (k >= 4 && k < 10)}, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL reconfig edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
    endtask

    task automatic test_invalid();
        do_reset();
        en = 3'b001;
        for (int k = 1; k <= 24; k++) begin
            idle();
            if (k == 2) write(0, 1, 0);
            if (k == 5) write(3, 4, 1);
            if (k == 7) write(1, 0, 3);
            push({2'b0, hi(k, 10, 10, 5)}, {2'b0, hi(k, 10, 10, 1)}, '0,
                 (k == 2 || k == 5 || k == 7));
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL invalid edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
    endtask

    // Clamp of H=0 and of H>=N, plus last-write-wins before a boundary.
    task automatic test_high_clamp();
        logic c0, t0;
        do_reset();
        en = 3'b001;
        for (int k = 1; k <= 36; k++) begin
            idle();
            if (k == 1)  write(0, 7, 0);
            if (k == 12) write(0, 9, 4);
            if (k == 13) write(0, 6, 6);
            c0 = (k < 17) ? hi(k, 10, 7, 3) : hi(k, 17, 6, 3);
            t0 = (k < 17) ? hi(k, 10, 7, 1) : hi(k, 17, 6, 1);
            push({2'b0, c0}, {2'b0, t0}, {2'b0, (k < 10) || (k >= 12 && k < 17)}, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL high_clamp edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
    endtask

    // A write on the wrap edge: the older pending pair takes effect there.
    task automatic test_back_to_back();
        logic c0, t0;
        do_reset();
        en = 3'b001;
        for (int k = 1; k <= 30; k++) begin
            idle();
            if (k == 3)  write(0, 4, 2);
            if (k == 10) write(0, 6, 3);
            c0 = (k < 14) ? hi(k, 10, 4, 2) : hi(k, 14, 6, 3);
            t0 = (k < 14) ? hi(k, 10, 4, 1) : hi(k, 14, 6, 1);
            push({2'b0, c0}, {2'b0, t0}, {2'b0, (k >= 3 && k < 14)}, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
    endtask

    task automatic test_disable_sync();
        logic c0, t0, c1, t1;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            idle();
            en   = (k >= 12 && k < 15) ? 3'b010 : 3'b011;
            sync = (k == 17);
            c0 = (k < 12) ? hi(k, 10, 10, 5) : hi(k, 27, 10, 5);
            t0 = (k < 12) ? hi(k, 10, 10, 1) : hi(k, 27, 10, 1);
            c1 = (k < 17) ? hi(k, 10, 10, 5) : hi(k, 27, 10, 5);
            t1 = (k < 17) ? hi(k, 10, 10, 1) : hi(k, 27, 10, 1);
            push({1'b0, c1, c0}, {1'b0, t1, t0}, '0, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL disable_sync edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
    endtask

    // Shadow applied while disabled, and sync coinciding with a write.
    task automatic test_pending_sync();
        logic c0, t0, c1, t1;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            idle();
            en = (k >= 5) ? 3'b011 : 3'b001;
            if (k == 2)  write(1, 4, 1);
            if (k == 11) write(0, 5, 2);
            if (k == 13) begin
                sync = 1'b1;
                write(0, 8, 4);
            end
            c0 = (k < 13) ? hi(k, 10, 10, 5) : hi(k, 18, 8, 4);
            t0 = (k < 13) ? hi(k, 10, 10, 1) : hi(k, 18, 8, 1);
            c1 = (k < 13) ? hi(k, 8, 4, 1) : hi(k, 17, 4, 1);
            t1 = c1;
            push({1'b0, c1, c0}, {1'b0, t1, t0},
                 {1'b0, (k == 2), (k >= 11 && k < 18)}, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL pending_sync edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 3'b001;
        for (int k = 1; k <= 11; k++) begin
            idle();
            if (k == 1)  write(0, 4, 2);
            if (k == 11) write(0, 6, 3);
            push({2'b0, hi(k, 10, 4, 2)}, {2'b0, hi(k, 10, 4, 1)},
                 {2'b0, (k < 10) || (k == 11)}, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL async_pre edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
        idle();
        reset = 1'b1;
        push('0, '0, '0, 1'b0);
        #2;
        e = sb.pop_front();
        tests_run++;
        if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL async_now: got clk=%b tick=%b pend=%b err=%b want all zero",
                     clk_out, tick, cfg_pending, cfg_err);
        end
        reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            push({2'b0, hi(k, 10, 10, 5)}, {2'b0, hi(k, 10, 10, 1)}, '0, 1'b0);
            advance();
            e = sb.pop_front();
            tests_run++;
            if ({clk_out, tick, cfg_pending, cfg_err} !== {e.clk, e.tk, e.pend, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL async_post edge %0d: got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         k, clk_out, tick, cfg_pending, cfg_err, e.clk, e.tk, e.pend, e.err);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_default_run();
        test_reconfig();
        test_invalid();
        test_high_clamp();
        test_back_to_back();
        test_disable_sync();
        test_pending_sync();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
